// File: rtl/cache_bus2_master.sv
// Bus2 line master: moves whole cache lines between the cache and main memory over A2/D2/C2.
// Optional MEM_TIMEOUT_EN bounds the wait for the memory RESPONSE and flags expiry on rsp_err.
`timescale 1ns/1ps
module cache_bus2_master #(
  parameter int ADDR2_BUS_SIZE = 15,
  parameter int DATA2_BUS_SIZE = 16,
  parameter int CTR2_BUS_SIZE  = 2,
  parameter int LINE_BITS      = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR2_BUS_SIZE-1:0] req_addr,
  input  logic [LINE_BITS-1:0]      req_wdata,
  output logic                      rsp_valid,
  output logic [LINE_BITS-1:0]      rsp_rdata,
  output logic                      rsp_err,
  inout  wire  [ADDR2_BUS_SIZE-1:0] A2_WIRE,
  inout  wire  [DATA2_BUS_SIZE-1:0] D2_WIRE,
  inout  wire  [CTR2_BUS_SIZE-1:0]  C2_WIRE,
  output logic [3:0]                dbg_state_o,
  output logic [2:0]                dbg_bus_oe_o
);
  localparam int BEATS = LINE_BITS / DATA2_BUS_SIZE;
  localparam int BW    = $clog2(BEATS) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

  if ((LINE_BITS % DATA2_BUS_SIZE) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cache_bus2_master: LINE_BITS must be a multiple of DATA2_BUS_SIZE, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [3:0] {
    IDLE, RD_CMD, RD_TA, RD_WAIT, RD_DATA, WR_DATA, WR_TA, WR_WAIT, DONE
  } state_t;

  // Handshake: a request transfers on a rising CLK edge where req_valid && req_ready;
  // rsp_valid is a one-cycle pulse with no backpressure from the cache.
  state_t                    state_q, state_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic [ADDR2_BUS_SIZE-1:0] addr_q, addr_d;
  logic [LINE_BITS-1:0]      wdata_q, wdata_d;
  logic [LINE_BITS-1:0]      rdata_q, rdata_d;
  logic                      a2_oe, d2_oe, c2_oe;
  logic [CTR2_BUS_SIZE-1:0]  c2_out;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    a2_oe     = 1'b0;
    d2_oe     = 1'b0;
    c2_oe     = 1'b0;
    c2_out    = '0;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          beat_d  = '0;
`ifdef MEM_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = req_write ? WR_DATA : RD_CMD;
        end
      end
      RD_CMD: begin
        a2_oe   = 1'b1;
        c2_oe   = 1'b1;
        c2_out  = C2_READ_LINE;
        state_d = RD_TA;
      end
      RD_TA: begin
`ifdef MEM_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Beats shift in from the top so beat 0 ends up in the least significant slice.
        if (C2_WIRE == C2_RESPONSE) begin
          rdata_d = {D2_WIRE, rdata_q[LINE_BITS-1:DATA2_BUS_SIZE]};
          beat_d  = BW'(1);
          state_d = RD_DATA;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      RD_DATA: begin
        rdata_d = {D2_WIRE, rdata_q[LINE_BITS-1:DATA2_BUS_SIZE]};
        beat_d  = beat_q + BW'(1);
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = DONE;
        end
      end
      WR_DATA: begin
        a2_oe   = (beat_q == '0);
        d2_oe   = 1'b1;
        c2_oe   = 1'b1;
        c2_out  = C2_WRITE_LINE;
        wdata_d = wdata_q >> DATA2_BUS_SIZE;
        beat_d  = beat_q + BW'(1);
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = WR_TA;
        end
      end
      WR_TA: begin
`ifdef MEM_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (C2_WIRE == C2_RESPONSE) begin
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Enables come straight from state_q, so an async reset releases the bus immediately.
  assign A2_WIRE = a2_oe ? addr_q : 'z;
  assign D2_WIRE = d2_oe ? wdata_q[DATA2_BUS_SIZE-1:0] : 'z;
  assign C2_WIRE = c2_oe ? c2_out : 'z;

  assign rsp_rdata    = rdata_q;
`ifdef MEM_TIMEOUT_EN
  assign rsp_err      = err_q;
`else
  assign rsp_err      = 1'b0;
`endif
  assign dbg_state_o  = state_q;
  assign dbg_bus_oe_o = {a2_oe, d2_oe, c2_oe};

endmodule

// File: tb/tb_cache_bus2_master.sv
// Directed bench for cache_bus2_master: a bus2 memory model plus a cycle-level expectation model.
`timescale 1ns/1ps
module tb_cache_bus2_master;
  localparam int AW = 15, DW = 16, CW = 2, LB = 128, BEATS = 8, TO = 10;

  logic CLK = 1'b0;
  logic RESET;
  logic req_valid, req_ready, req_write, rsp_valid, rsp_err;
  logic [AW-1:0] req_addr;
  logic [LB-1:0] req_wdata, rsp_rdata;
  wire  [AW-1:0] a2_w;
  wire  [DW-1:0] d2_w;
  wire  [CW-1:0] c2_w;
  logic [3:0]    dbg_state;
  logic [2:0]    dbg_oe;

  // memory side of bus2
  logic          mem_c2_oe, mem_d2_oe, mem_abort, mem_silent;
  logic [CW-1:0] mem_c2;
  logic [DW-1:0] mem_d2;
  logic [LB-1:0] mem_line, wr_seen;
  int            mem_idle;

  assign c2_w = mem_c2_oe ? mem_c2 : 'z;
  assign d2_w = mem_d2_oe ? mem_d2 : 'z;

  cache_bus2_master #(
    .ADDR2_BUS_SIZE(AW), .DATA2_BUS_SIZE(DW), .CTR2_BUS_SIZE(CW),
    .LINE_BITS(LB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .A2_WIRE(a2_w), .D2_WIRE(d2_w), .C2_WIRE(c2_w),
    .dbg_state_o(dbg_state), .dbg_bus_oe_o(dbg_oe)
  );

  // clock / cycle count / watchdog
  int cyc = 0;
  always #5 CLK = ~CLK;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory model: answers READ_LINE with mem_line beats, WRITE_LINE with one RESPONSE
  initial begin
    mem_c2_oe = 1'b0; mem_d2_oe = 1'b0; mem_c2 = '0; mem_d2 = '0; wr_seen = '0; mem_abort = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET && c2_w == 2'd2 && !mem_silent) begin
        repeat (2 + mem_idle) @(posedge CLK);
        #1 mem_c2 = 2'd1; mem_c2_oe = 1'b1; mem_d2_oe = 1'b1; mem_d2 = mem_line[DW-1:0];
        for (int i = 1; i < BEATS; i++) begin
          @(posedge CLK);
          #1 mem_d2 = mem_line[i*DW +: DW];
        end
        @(posedge CLK);
        #1 mem_c2_oe = 1'b0; mem_d2_oe = 1'b0;
      end else if (RESET && c2_w == 2'd3) begin
        mem_abort = 1'b0;
        for (int i = 0; i < BEATS; i++) begin
          if (i > 0) @(negedge CLK);
          if (!RESET) begin
            mem_abort = 1'b1;
            break;
          end
          wr_seen[i*DW +: DW] = d2_w;
        end
        if (!mem_abort) begin
          repeat (2 + mem_idle) @(posedge CLK);
          #1 mem_c2 = 2'd1; mem_c2_oe = 1'b1;
          @(posedge CLK);
          #1 mem_c2_oe = 1'b0;
        end
      end
    end
  end

  // expectation model: a transaction is a timeline of k = cycles since acceptance
  logic          m_busy = 1'b0, m_wr, m_err;
  logic [AW-1:0] m_addr;
  logic [LB-1:0] m_wdata, m_line, last_rdata;
  int            m_k, m_done_k, acc_cyc, rsp_cyc, lat, rsp_cnt = 0;
  int            rdcmd_cycles, a2_cycles, d2_cycles;
  logic          last_err;
  int            acc_q[$];

  initial forever begin
    logic [2:0] e_oe;
    logic       e_rsp;
    @(negedge CLK);
    if (!RESET) begin
      m_busy = 1'b0;
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_bus_oe", dbg_oe, 0);
    end else begin
      e_rsp = m_busy && (m_k == m_done_k);
      e_oe  = 3'b000;
      if (m_busy && !m_wr && m_k == 0) e_oe = 3'b101;
      if (m_busy && m_wr && m_k < BEATS) e_oe = {m_k == 0, 2'b11};
      chk("ready", req_ready, !m_busy);
      chk("rsp_valid", rsp_valid, e_rsp);
      chk("bus_oe", dbg_oe, e_oe);
      chk("c2_contention", mem_c2_oe && dbg_oe[0], 0);
      chk("d2_contention", mem_d2_oe && dbg_oe[1], 0);
      if (e_oe[0]) chk("c2_cmd", c2_w, m_wr ? 2'd3 : 2'd2);
      if (e_oe[2]) chk("a2_addr", a2_w, m_addr);
      if (e_oe[1]) chk("d2_beat", d2_w, m_wdata[m_k*DW +: DW]);
      if (e_rsp) begin
        chk("rsp_err", rsp_err, m_err);
        if (!m_wr) chk("rsp_rdata", rsp_rdata, m_line);
      end
      if (rsp_valid) begin
        lat = cyc - acc_cyc; rsp_cyc = cyc; rsp_cnt++;
        last_err = rsp_err; last_rdata = rsp_rdata;
      end
      if (dbg_oe[0] && c2_w == 2'd2) rdcmd_cycles++;
      if (dbg_oe[2]) a2_cycles++;
      if (dbg_oe[1]) d2_cycles++;
      if (m_busy) begin
        if (m_k == m_done_k) m_busy = 1'b0;
        else m_k++;
      end else if (req_valid) begin
        m_busy = 1'b1; m_k = 0; m_wr = req_write; m_addr = req_addr; m_wdata = req_wdata;
        m_err = 1'b0; m_line = mem_line; acc_cyc = cyc; acc_q.push_back(cyc);
        if (req_write) m_done_k = BEATS + 1 + mem_idle + 1;
        else if (mem_silent) begin
          m_done_k = 2 + TO; m_err = 1'b1; m_line = '0;
        end else m_done_k = 2 + mem_idle + BEATS;
      end
    end
  end

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    @(negedge CLK);
    while (!req_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_timeout", req_ready, 1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    @(negedge CLK);
    while (!rsp_valid && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("rsp_timeout", rsp_valid, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [LB-1:0] wd,
                       input int idle, input logic [LB-1:0] line, input logic silent);
    mem_idle = idle; mem_line = line; mem_silent = silent;
    rdcmd_cycles = 0; a2_cycles = 0; d2_cycles = 0;
    req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    wait_ready();
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  localparam logic [LB-1:0] RD_LINE  = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [LB-1:0] WR_LINE  = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
  localparam logic [LB-1:0] RD_LINE2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    int r1, n0, c0;
    RESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_idle = 0; mem_line = '0; mem_silent = 1'b0;
    #2 RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_state_idle", dbg_state, 0);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // read, memory idles 4 cycles after turnaround
    issue(1'b0, 15'h1A2B, '0, 4, RD_LINE, 1'b0);
    wait_rsp();
    chk("read_latency", lat, 15);
    chk("read_line", last_rdata, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("read_cmd_cycles", rdcmd_cycles, 1);

    // write; W=2 wait-state cycles, the second carrying RESPONSE
    issue(1'b1, 15'h0040, WR_LINE, 1, '0, 1'b0);
    wait_rsp();
    chk("write_latency", lat, 12);
    chk("write_beats_seen", wr_seen, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
    chk("write_a2_cycles", a2_cycles, 1);
    chk("write_d2_cycles", d2_cycles, 8);

    // back-to-back: read then write, req_valid held throughout
    mem_idle = 2; mem_line = RD_LINE2; mem_silent = 1'b0;
    req_write = 1'b0; req_addr = 15'h0123; req_valid = 1'b1;
    wait_ready();
    @(posedge CLK);
    #1 req_write = 1'b1; req_addr = 15'h0456; req_wdata = RD_LINE;
    wait_rsp();
    r1 = rsp_cyc;
    wait_ready();
    @(posedge CLK);
    #1 req_valid = 1'b0;
    chk("b2b_gap", acc_cyc - r1, 1);
    wait_rsp();

    // request pulse while waiting for read data is ignored
    n0 = acc_q.size();
    issue(1'b0, 15'h0ABC, '0, 6, RD_LINE, 1'b0);
    repeat (4) @(posedge CLK);
    #1 req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h7FFF; req_wdata = WR_LINE;
    @(negedge CLK);
    chk("busy_ready", req_ready, 0);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    wait_rsp();
    chk("busy_accepts", acc_q.size() - n0, 1);
    repeat (3) @(posedge CLK);
    #1;

    // read with RESPONSE in the first wait cycle
    issue(1'b0, 15'h3FFF, '0, 0, RD_LINE2, 1'b0);
    wait_rsp();
    chk("read_w0_latency", lat, 11);
    chk("read_w0_line", last_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

    // async reset during write beat 3
    c0 = rsp_cnt;
    issue(1'b1, 15'h0100, WR_LINE, 1, '0, 1'b0);
    repeat (3) @(posedge CLK);
    #3 RESET = 1'b0;
    #1;
    chk("mid_reset_bus_oe", dbg_oe, 0);
    chk("mid_reset_ready", req_ready, 1);
    chk("mid_reset_state", dbg_state, 0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    chk("mid_reset_no_rsp", rsp_cnt - c0, 0);

`ifdef MEM_TIMEOUT_EN
    // silent memory: timeout 10 cycles after entering RD_WAIT
    issue(1'b0, 15'h0777, '0, 0, RD_LINE, 1'b1);
    wait_rsp();
    chk("timeout_latency", lat, 13);
    chk("timeout_err", last_err, 1);
    chk("timeout_rdata", last_rdata, 0);
    mem_silent = 1'b0;
`endif

    repeat (3) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_bus2_master.md
# cache_bus2_master

Bus2 master that sits directly upstream of the memory controller and moves whole cache lines between the cache and main memory. It accepts one line request at a time from the cache (a line read or a line write), drives the command and line address onto bus2, and transfers the line over D2 in DATA2_BUS_SIZE-bit beats. It releases the shared wires at the protocol's ownership hand-off points and returns read data or write completion to the cache through a single-cycle response pulse.

## Interface
- ADDR2_BUS_SIZE, 15, line address width on A2
- DATA2_BUS_SIZE, 16, D2 beat width
- CTR2_BUS_SIZE, 2, C2 command width
- LINE_BITS, 128, cache line width; BEATS = LINE_BITS/DATA2_BUS_SIZE (8); must divide exactly
- TIMEOUT_CYCLES, 255, wait limit; used only with MEM_TIMEOUT_EN
- CLK  in  1  clock; all logic is on the rising edge
- RESET  in  1  asynchronous, active-low reset
- req_valid  in  1  cache request present
- req_ready  out  1  request accepted when it is high together with req_valid
- req_write  in  1  1 = write line, 0 = read line
- req_addr  in  ADDR2_BUS_SIZE  line address
- req_wdata  in  LINE_BITS  write line; beat i = bits [i*D+D-1 : i*D]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  LINE_BITS  read line; valid while rsp_valid is high
- rsp_err  out  1  timeout flag; valid while rsp_valid is high
- A2_WIRE  inout  ADDR2_BUS_SIZE  bus2 address
- D2_WIRE  inout  DATA2_BUS_SIZE  bus2 data
- C2_WIRE  inout  CTR2_BUS_SIZE  bus2 command: NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3

## Operation
- States: IDLE, RD_CMD, RD_TA, RD_WAIT, RD_DATA, WR_DATA, WR_TA, WR_WAIT, DONE.
- IDLE: req_ready=1. On req_valid, register addr, write, wdata.
  - Write requests go to WR_DATA with beat=0.
  - Read requests go to RD_CMD.
- RD_CMD (1 cycle): drive C2=READ_LINE and A2=addr; D2 is z. Next state: RD_TA.
- RD_TA (1 cycle): all bus2 outputs are z; C2 is ignored (turnaround). Next state: RD_WAIT.
- RD_WAIT: when the sampled C2==RESPONSE, capture D2 into beat 0 and go to RD_DATA with beat=1. Otherwise stay.
- RD_DATA: each cycle, capture D2 into beat[beat] and increment beat. After beat BEATS-1 is captured, go to DONE.
  - The memory holds C2=RESPONSE for all beats. The master does not check C2 in this state.
- WR_DATA (BEATS cycles): drive C2=WRITE_LINE and D2=wdata beat[beat].
  - A2=addr is driven on beat 0 only; A2 is z afterwards.
  - After beat BEATS-1, go to WR_TA.
- WR_TA (1 cycle): all bus2 outputs are z; C2 is ignored. Next state: WR_WAIT.
- WR_WAIT: when the sampled C2==RESPONSE (one cycle), go to DONE.
- DONE (1 cycle): rsp_valid=1, req_ready=0. Next state: IDLE.
  - rsp_rdata holds the assembled line for reads; its value is don't-care for writes.
- Outside the driving states, A2, D2 and C2 are all z. The master never drives D2 during a read.
- req_valid while not in IDLE is ignored; req_ready=0 in every state except IDLE.

## Timing
- Reset (async, RESET=0): state=IDLE, beat=0, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Bus2 outputs go to z immediately, without waiting for a clock edge.
  - Any in-flight transaction is dropped and no response is produced.
  - Release is synchronous to the next CLK edge.
- Read latency, from the accepting edge to the rsp_valid cycle: 2 + W + BEATS + 1 cycles, where W is the number of cycles the memory waits after turnaround before its first RESPONSE.
- Write latency: BEATS + 1 + W + 1 cycles.
- Back-to-back operation: the next request can be accepted in the cycle after DONE. Minimum spacing is one idle cycle.
- Beat counter: $clog2(BEATS)+1 bits; it wraps only through the state change.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to RD_WAIT or WR_WAIT and increments each waiting cycle.
  - When it reaches TIMEOUT_CYCLES without a RESPONSE, go to DONE with rsp_err=1 and rsp_rdata=0.
  - The counter does not run in RD_DATA.
- MEM_TIMEOUT_EN undefined: the master waits indefinitely; rsp_err is tied to 0 and there is no counter logic.

## Test plan
- Reset mid-write: assert RESET=0 during WR_DATA beat 3.
  - Bus2 outputs go to z the same cycle.
  - After release: state IDLE, req_ready=1, no rsp_valid.
- Read, addr=0x1A2B, memory W=4, memory beats 0x0000..0x0007:
  - C2=2 and A2=0x1A2B for exactly 1 cycle, then z.
  - rsp_valid 15 cycles after acceptance.
  - rsp_rdata=0x0007_0006_..._0000.
- Write, addr=0x0040, wdata=0x1111..8888 (beat i = 0x1111*(i+1)), memory responds after W=2:
  - D2 shows 0x1111..0x8888 on 8 consecutive cycles with C2=3.
  - A2=0x0040 on beat 0 only.
  - rsp_valid 12 cycles after acceptance.
- Back-to-back: read then write request held on req_valid.
  - The second request is accepted exactly 1 cycle after the first rsp_valid.
  - No cycle has both the master and the memory model driving C2.
- Request during busy: req_valid pulsed during RD_WAIT is not accepted (req_ready=0); the captured address is unchanged.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=10, memory silent: rsp_valid with rsp_err=1 and rsp_rdata=0, 10 cycles after entering RD_WAIT.
